// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, applies hazard stall/flush and execute redirects, and counts fetches and bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter int          COUNT_W      = 32
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               flushD,
  input  logic               pcsrcE,
  input  logic [31:0]        pctargetE,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instrD,
  output logic [31:0]        pcD,
  output logic [31:0]        pcplus4D,
  output logic               validD,
  output logic               misalignD,
  output logic [COUNT_W-1:0] fetch_count,
  output logic [COUNT_W-1:0] bubble_count
);

  logic [31:0]        r_pcf;
  logic [31:0]        r_instrd;
  logic [31:0]        r_pcd;
  logic [31:0]        r_pcplus4d;
  logic               r_validd;
  logic               r_misalignd;
  logic [COUNT_W-1:0] r_fetch_count;
  logic [COUNT_W-1:0] r_bubble_count;

  logic [31:0] w_pcplus4f;
  logic [31:0] w_redirect_pc;
  logic        w_misalignf;
  logic        w_effflush;
  logic        w_load_d;
  logic [31:0] w_instrf;

  // PC+4 wraps naturally at 2^32 because the sum is truncated to 32 bits.
  assign w_pcplus4f    = r_pcf + 32'd4;
  assign w_redirect_pc = {pctargetE[31:1], 1'b0};
  assign w_misalignf   = r_pcf[1];
  assign w_effflush    = flushD | pcsrcE;
  assign w_load_d      = ~w_effflush & ~stallD;
  assign w_instrf      = w_misalignf ? NOP_INSTR : imem_rdata;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_pcf <= RESET_VECTOR;
    end else if (pcsrcE) begin
      r_pcf <= w_redirect_pc;
    end else if (!stallF) begin
      r_pcf <= w_pcplus4f;
    end
  end

  // A redirect kills the wrong-path word, and a flush wins over a decode stall.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_instrd    <= NOP_INSTR;
      r_pcd       <= 32'd0;
      r_pcplus4d  <= 32'd0;
      r_validd    <= 1'b0;
      r_misalignd <= 1'b0;
    end else if (w_effflush) begin
      r_instrd    <= NOP_INSTR;
      r_pcd       <= 32'd0;
      r_pcplus4d  <= 32'd0;
      r_validd    <= 1'b0;
      r_misalignd <= 1'b0;
    end else if (w_load_d) begin
      r_instrd    <= w_instrf;
      r_pcd       <= r_pcf;
      r_pcplus4d  <= w_pcplus4f;
      r_validd    <= 1'b1;
      r_misalignd <= w_misalignf;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_fetch_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_load_d) begin
        r_fetch_count <= r_fetch_count + 1'b1;
      end
      if (w_effflush) begin
        r_bubble_count <= r_bubble_count + 1'b1;
      end
    end
  end

  assign imem_addr    = r_pcf;
  assign instrD       = r_instrd;
  assign pcD          = r_pcd;
  assign pcplus4D     = r_pcplus4d;
  assign validD       = r_validd;
  assign misalignD    = r_misalignd;
  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns 0xA0 + address, outputs sampled on the falling edge.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        rst;
  logic        stallF, stallD, flushD, pcsrcE;
  logic [31:0] pctargetE;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, pcD, pcplus4D;
  logic        validD, misalignD;
  logic [31:0] fetch_count, bubble_count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage dut (
    .CLK(CLK), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .pcsrcE(pcsrcE), .pctargetE(pctargetE), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
    .validD(validD), .misalignD(misalignD), .fetch_count(fetch_count),
    .bubble_count(bubble_count)
  );

  always #5 CLK = ~CLK;
  assign imem_rdata = imem_addr + 32'h0000_00A0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_d(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic v, input logic m);
    check({tag, ".instrD"},   instrD,   ins);
    check({tag, ".pcD"},      pcD,      pc);
    check({tag, ".pcplus4D"}, pcplus4D, pc4);
    check({tag, ".validD"},   {31'd0, validD},    {31'd0, v});
    check({tag, ".misalignD"},{31'd0, misalignD}, {31'd0, m});
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] f, input logic [31:0] b);
    check({tag, ".fetch_count"},  fetch_count,  f);
    check({tag, ".bubble_count"}, bubble_count, b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stallF = 0; stallD = 0; flushD = 0; pcsrcE = 0; pctargetE = 32'd0;
    #2;
    check("rst.pcf", imem_addr, 32'h0);
    check_d("rst", 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
    check_cnt("rst", 32'd0, 32'd0);
    #5 rst = 1'b0;
    @(negedge CLK);

    // Free-running fetch
    step(); check_d("run0", 32'hA0, 32'h0, 32'h4, 1'b1, 1'b0);
    step(); check_d("run1", 32'hA4, 32'h4, 32'h8, 1'b1, 1'b0);
    step(); check_d("run2", 32'hA8, 32'h8, 32'hC, 1'b1, 1'b0);
    step(); check_d("run3", 32'hAC, 32'hC, 32'h10, 1'b1, 1'b0);
    check_cnt("run", 32'd4, 32'd0);
    check("run.pcf", imem_addr, 32'h10);

    // Full stall for three cycles
    stallF = 1; stallD = 1;
    for (int i = 0; i < 3; i++) step();
    check("stall.pcf", imem_addr, 32'h10);
    check_d("stall", 32'hAC, 32'hC, 32'h10, 1'b1, 1'b0);
    check_cnt("stall", 32'd4, 32'd0);
    stallF = 0; stallD = 0;
    step(); check_d("rel0", 32'hB0, 32'h10, 32'h14, 1'b1, 1'b0);
    step(); check_d("rel1", 32'hB4, 32'h14, 32'h18, 1'b1, 1'b0);
    check_cnt("rel", 32'd6, 32'd0);

    // Redirect coincident with stallF
    pcsrcE = 1; pctargetE = 32'h200; stallF = 1;
    step();
    check("redir.pcf", imem_addr, 32'h200);
    check_d("redir", 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
    check_cnt("redir", 32'd6, 32'd1);
    pcsrcE = 0; stallF = 0;
    step(); check_d("tgt", 32'h2A0, 32'h200, 32'h204, 1'b1, 1'b0);
    check_cnt("tgt", 32'd7, 32'd1);

    // Flush wins over stallD
    flushD = 1; stallD = 1;
    step();
    check_d("flush", 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
    check_cnt("flush", 32'd7, 32'd2);
    check("flush.pcf", imem_addr, 32'h208);
    flushD = 0; stallD = 0;

    // Misaligned target: bit0 cleared, bit1 kept
    pcsrcE = 1; pctargetE = 32'h303;
    step();
    check("mis.pcf", imem_addr, 32'h302);
    check_cnt("mis.redir", 32'd7, 32'd3);
    pcsrcE = 0;
    step(); check_d("mis", 32'h13, 32'h302, 32'h306, 1'b1, 1'b1);
    check_cnt("mis", 32'd8, 32'd3);

    // PC wrap at the top of the address space
    pcsrcE = 1; pctargetE = 32'hFFFF_FFFC;
    step();
    check("wrap.pcf0", imem_addr, 32'hFFFF_FFFC);
    pcsrcE = 0;
    step();
    check("wrap.pcf1", imem_addr, 32'h0);
    check_d("wrap", 32'h9C, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
    check_cnt("wrap", 32'd9, 32'd4);

    // Asynchronous reset between edges
    #1 rst = 1'b1;
    #1;
    check("arst.pcf", imem_addr, 32'h0);
    check_d("arst", 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
    check_cnt("arst", 32'd0, 32'd0);
    #1 rst = 1'b0;
    step(); check_d("post", 32'hA0, 32'h0, 32'h4, 1'b1, 1'b0);
    check_cnt("post", 32'd1, 32'd0);

    // stallF alone: IF/ID recaptures the same PC and keeps counting
    stallF = 1;
    step(); check_d("sf0", 32'hA4, 32'h4, 32'h8, 1'b1, 1'b0);
    step(); check_d("sf1", 32'hA4, 32'h4, 32'h8, 1'b1, 1'b0);
    check_cnt("sf", 32'd3, 32'd0);
    check("sf.pcf", imem_addr, 32'h4);
    stallF = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
